// File: rtl/mem_access_unit.sv
// Memory access unit for a multicycle core: turns controller fetch/load/store requests into a
// req/ack transaction, owns the Instruction and Data Registers, and flags timeouts/misalignment.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  i_or_d,
  input  logic                  ir_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [5:0]            op,
  output logic [5:0]            funct,
  output logic [DATA_WIDTH-1:0] data_reg,
  output logic                  mem_stall,
  output logic                  mem_done,
  output logic                  bus_error
);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;
  typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  start;
  logic [ADDR_WIDTH-1:0] addr_sel;

  assign start    = mem_write | ir_write | mem_read;
  assign addr_sel = i_or_d ? alu_out : pc;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = addr_sel;
          wdata_d = write_data;
          cnt_d   = '0;
          // Store beats fetch beats load when several are raised together.
          if (mem_write)     kind_d = KindStore;
          else if (ir_write) kind_d = KindFetch;
          else               kind_d = KindLoad;
          state_d = (addr_sel[1:0] != 2'b00) ? StErr : StReq;
        end
      end
      StReq: begin
        // An ack on the last allowed cycle still completes the access.
        if (mem_ack) begin
          if (kind_q == KindFetch) instr_d = mem_rdata;
          if (kind_q == KindLoad)  data_d  = mem_rdata;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      kind_q  <= KindFetch;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req && (kind_q == KindStore);
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_done  = (state_q == StDone);
  assign bus_error = (state_q == StErr);
  // Stall in the request cycle itself so the controller never runs ahead of memory.
  assign mem_stall = ((state_q == StIdle) && start) || mem_req || bus_error;

  assign instr    = instr_q;
  assign op       = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign data_reg = data_q;

endmodule
